aer_out_rr_arbiter: RTL and testbench
=====================================

AER_OUT_RR_ARBITER -- requirements
Module: aer_out_rr_arbiter

Interface
REQ-001 The block SHALL have parameter CORE_NUM, default 256, giving the number of core AER output requesters.
REQ-002 The block SHALL have parameter AER_WIDTH, default 6, giving the core-local AER address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 1024, giving the watchdog limit in cycles (used only under AER_ARB_TIMEOUT_EN).
REQ-004 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-005 clk  input  1  single clock.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 CORE_AEROUT_REQ  input  CORE_NUM  per-core 4-phase request.
REQ-008 CORE_AEROUT_ADDR  input  CORE_NUM x AER_WIDTH  per-core event address.
REQ-009 CORE_AEROUT_ACK  output  CORE_NUM  per-core 4-phase acknowledge, one-hot or zero.
REQ-010 AEROUT_REQ  output  1  merged downstream request.
REQ-011 AEROUT_ADDR  output  $clog2(CORE_NUM)+AER_WIDTH  {granted core index, core address}.
REQ-012 AEROUT_ACK  input  1  downstream acknowledge.
REQ-013 BUSY  output  1  high whenever state is not IDLE.
REQ-014 TIMEOUT_ERR  output  1  sticky watchdog flag (tied 0 without AER_ARB_TIMEOUT_EN).

Function
REQ-015 The FSM SHALL have states IDLE, SEND, DROP and CORE_ACK.
REQ-016 IDLE: when any CORE_AEROUT_REQ is high, the block SHALL grant the first requester at or after the rotating pointer, wrapping past index CORE_NUM-1 to 0, and SHALL enter SEND on the next edge.
REQ-017 At grant, the block SHALL register the granted index and its address into AEROUT_ADDR, and SHALL hold them stable until the next grant.
REQ-018 SEND: AEROUT_REQ=1; on AEROUT_ACK=1 the block SHALL enter DROP.
REQ-019 DROP: AEROUT_REQ=0; on AEROUT_ACK=0 the block SHALL enter CORE_ACK.
REQ-020 CORE_ACK: CORE_AEROUT_ACK[granted]=1; when CORE_AEROUT_REQ[granted]=0, the block SHALL deassert the ack, set the pointer to granted+1 mod CORE_NUM, and return to IDLE.
REQ-021 Latency: a request sampled high in IDLE at edge N SHALL produce AEROUT_REQ=1 after edge N+1; minimum event period SHALL be 4 cycles plus handshake waits.
REQ-022 All outputs SHALL be registered; no combinational path from any input to AEROUT_REQ or CORE_AEROUT_ACK.
REQ-023 Requests arriving during a non-IDLE state SHALL be held pending and arbitrated only in IDLE; no request SHALL be lost or duplicated.
REQ-024 Simultaneous requests: exactly one grant per IDLE cycle; under continuous requests from all cores, each core SHALL be served once per CORE_NUM grants.
REQ-025 A requester withdrawing its REQ before its ACK (protocol violation) SHALL not affect the FSM; the event completes downstream normally.

Reset
REQ-026 While rst_n=0 at an edge: state=IDLE, pointer=0, AEROUT_REQ=0, CORE_AEROUT_ACK=0, AEROUT_ADDR=0, BUSY=0, TIMEOUT_ERR=0, watchdog counter=0.
REQ-027 Reset asserted mid-handshake SHALL abort it; the aborted event SHALL not be retried by the block.

Configuration
REQ-028 Macro AER_ARB_TIMEOUT_EN: when defined, a counter SHALL count cycles spent in SEND or DROP, cleared on state change; on reaching TIMEOUT it SHALL set TIMEOUT_ERR, drop AEROUT_REQ, and enter CORE_ACK, discarding the event.
REQ-029 Without AER_ARB_TIMEOUT_EN, the counter SHALL be absent, the block SHALL wait indefinitely, and TIMEOUT_ERR SHALL be constant 0.

Structure
REQ-030 The FSM state enum and the AEROUT_ADDR field-split constants SHALL live in a shared package snn_ff_pkg.
REQ-031 One sub-module rr_priority_pick (combinational rotating-priority find-first returning index and valid) SHALL be instantiated.

Verification
REQ-032 Single request: CORE_NUM=4, core 2 REQ with ADDR=0x15 -> AEROUT_ADDR={2'd2,6'h15}, AEROUT_REQ after 1 cycle, full 4-phase completes, pointer=3.
REQ-033 Fairness: cores 0,1,3 hold REQ permanently from pointer 0 -> grant order 0,1,3,0,1,3.
REQ-034 Wrap: pointer=3, requests on cores 1 and 3 -> grant 3, then 1.
REQ-035 Backpressure: AEROUT_ACK delayed 50 cycles -> AEROUT_REQ and AEROUT_ADDR stay stable, no CORE_AEROUT_ACK until the downstream ack returns low.
REQ-036 Mid-handshake reset: rst_n=0 in DROP -> next cycle all outputs 0, state IDLE, pointer 0.
REQ-037 With AER_ARB_TIMEOUT_EN and TIMEOUT=16, AEROUT_ACK never asserted -> TIMEOUT_ERR=1 after 16 cycles in SEND, requester acked, BUSY returns 0.

Source files
------------

// File: rtl/snn_ff_pkg.sv
// ---------------------------------------------------------------------------
// snn_ff_pkg
// Shared definitions for the AER output round-robin arbiter.
//   - arb_state_e    : handshake FSM states (IDLE, SEND, DROP, CORE_ACK)
//   - aer_idx_width  : width of the granted-core index field
//   - aer_addr_width : total merged AER address width {core index, local addr}
//   - aer_core_lsb   : LSB position of the core index field in the merged
//                      address (the core-local address sits below it)
// ---------------------------------------------------------------------------
package snn_ff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_DROP     = 2'd2,
        ST_CORE_ACK = 2'd3
    } arb_state_e;

    // A single-core build still needs a one-bit index field to stay legal.
    function automatic int aer_idx_width(input int core_num);
        return (core_num > 1) ? $clog2(core_num) : 1;
    endfunction

    function automatic int aer_addr_width(input int core_num, input int aer_width);
        return aer_idx_width(core_num) + aer_width;
    endfunction

    function automatic int aer_core_lsb(input int aer_width);
        return aer_width;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// ---------------------------------------------------------------------------
// rr_priority_pick
// Combinational rotating-priority find-first. Returns the first asserted
// request at or after ptr, wrapping from N-1 back to 0.
// Ports:
//   req   [N-1:0]      request vector
//   ptr   [IDX_W-1:0]  highest-priority index for this search
//   idx   [IDX_W-1:0]  winning index (0 when nothing is requesting)
//   valid              at least one request is asserted
// ---------------------------------------------------------------------------
module rr_priority_pick
    import snn_ff_pkg::*;
#(
    parameter int N = 256
) (
    input  logic [N-1:0]                req,
    input  logic [aer_idx_width(N)-1:0] ptr,
    output logic [aer_idx_width(N)-1:0] idx,
    output logic                        valid
);

    localparam int IDX_W = aer_idx_width(N);
    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk offsets from the farthest to the nearest so that the closest
    // requester to ptr is the last one written and therefore wins.
    always_comb begin
        valid    = 1'b0;
        idx      = '0;
        cand     = '0;
        cand_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (cand >= N_W) begin
                cand = cand - N_W;
            end
            cand_idx = cand[IDX_W-1:0];
            if (req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/aer_out_rr_arbiter.sv
// ---------------------------------------------------------------------------
// aer_out_rr_arbiter
// Merges CORE_NUM per-core 4-phase AER output channels into one downstream
// 4-phase channel using round-robin arbitration. The downstream address is
// {granted core index, core-local address}. All outputs come from flops.
// Optional feature macro: AER_ARB_TIMEOUT_EN adds a watchdog that abandons
// an event stuck in SEND/DROP for TIMEOUT cycles and raises TIMEOUT_ERR.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   CORE_AEROUT_REQ    per-core request
//   CORE_AEROUT_ADDR   per-core address, core i at [i*AER_WIDTH +: AER_WIDTH]
//   CORE_AEROUT_ACK    per-core acknowledge (one-hot or zero)
//   AEROUT_REQ/ADDR    merged downstream request and address
//   AEROUT_ACK         downstream acknowledge
//   BUSY               FSM not idle
//   TIMEOUT_ERR        sticky watchdog flag (0 without the macro)
// ---------------------------------------------------------------------------
module aer_out_rr_arbiter
    import snn_ff_pkg::*;
#(
    parameter int CORE_NUM  = 256,
    parameter int AER_WIDTH = 6,
    parameter int TIMEOUT   = 1024
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [CORE_NUM-1:0]                          CORE_AEROUT_REQ,
    input  logic [CORE_NUM*AER_WIDTH-1:0]                CORE_AEROUT_ADDR,
    output logic [CORE_NUM-1:0]                          CORE_AEROUT_ACK,
    output logic                                         AEROUT_REQ,
    output logic [aer_addr_width(CORE_NUM, AER_WIDTH)-1:0] AEROUT_ADDR,
    input  logic                                         AEROUT_ACK,
    output logic                                         BUSY,
    output logic                                         TIMEOUT_ERR
);

    localparam int IDX_W   = aer_idx_width(CORE_NUM);
    localparam int ADDR_W  = aer_addr_width(CORE_NUM, AER_WIDTH);
    localparam int IDX_LSB = aer_core_lsb(AER_WIDTH);

    arb_state_e            state_q, state_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      grant_q, grant_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  aer_req_q, aer_req_d;
    logic [CORE_NUM-1:0]   core_ack_q, core_ack_d;
    logic                  busy_q, busy_d;

    logic [IDX_W-1:0]      pick_idx;
    logic                  pick_valid;
    logic [AER_WIDTH-1:0]  pick_addr;
    logic [CORE_NUM-1:0]   grant_onehot;
    logic                  tmo_fire;

    rr_priority_pick #(
        .N (CORE_NUM)
    ) u_pick (
        .req   (CORE_AEROUT_REQ),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign pick_addr = CORE_AEROUT_ADDR[int'(pick_idx)*AER_WIDTH +: AER_WIDTH];

    always_comb begin
        grant_onehot          = '0;
        grant_onehot[grant_q] = 1'b1;
    end

`ifdef AER_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            tmo_err_q, tmo_err_d;

    // Fires only when the normal handshake would not advance this cycle, so
    // a late-but-valid ack on the last cycle still completes normally.
    assign tmo_fire = (wd_cnt_q == WD_W'(TIMEOUT - 1)) &&
                      (((state_q == ST_SEND) && !AEROUT_ACK) ||
                       ((state_q == ST_DROP) &&  AEROUT_ACK));

    // Counter tracks time spent in the current SEND or DROP visit only.
    always_comb begin
        wd_cnt_d  = '0;
        tmo_err_d = tmo_err_q | tmo_fire;
        if ((state_d == state_q) && ((state_q == ST_SEND) || (state_q == ST_DROP))) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_cnt_q  <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign TIMEOUT_ERR = tmo_err_q;
`else
    assign tmo_fire    = 1'b0;
    assign TIMEOUT_ERR = 1'b0;
`endif

    // Outputs are computed as next-state values and registered alongside the
    // state, so no input reaches an output without passing through a flop.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        aer_req_d  = aer_req_q;
        core_ack_d = core_ack_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d                   = ST_SEND;
                    grant_d                   = pick_idx;
                    addr_d[ADDR_W-1:IDX_LSB]  = pick_idx;
                    addr_d[IDX_LSB-1:0]       = pick_addr;
                    aer_req_d                 = 1'b1;
                end
            end
            ST_SEND: begin
                if (AEROUT_ACK) begin
                    state_d   = ST_DROP;
                    aer_req_d = 1'b0;
                end else if (tmo_fire) begin
                    state_d    = ST_CORE_ACK;
                    aer_req_d  = 1'b0;
                    core_ack_d = grant_onehot;
                end
            end
            ST_DROP: begin
                if (!AEROUT_ACK || tmo_fire) begin
                    state_d    = ST_CORE_ACK;
                    core_ack_d = grant_onehot;
                end
            end
            ST_CORE_ACK: begin
                // A requester that already withdrew is released on the
                // first CORE_ACK cycle; the event was still delivered.
                if (!CORE_AEROUT_REQ[grant_q]) begin
                    state_d    = ST_IDLE;
                    core_ack_d = '0;
                    ptr_d      = (grant_q == IDX_W'(CORE_NUM - 1)) ? '0
                                                                   : grant_q + IDX_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                aer_req_d  = 1'b0;
                core_ack_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            addr_q     <= '0;
            aer_req_q  <= 1'b0;
            core_ack_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            aer_req_q  <= aer_req_d;
            core_ack_q <= core_ack_d;
            busy_q     <= busy_d;
        end
    end

    assign CORE_AEROUT_ACK = core_ack_q;
    assign AEROUT_REQ      = aer_req_q;
    assign AEROUT_ADDR     = addr_q;
    assign BUSY            = busy_q;

endmodule

// File: tb/tb_aer_out_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_aer_out_rr_arbiter
// Scoreboard bench for aer_out_rr_arbiter with CORE_NUM=4, AER_WIDTH=6.
// Stimulus pushes hand-computed {core, addr} grants into a queue; a monitor
// pops one entry on every rising AEROUT_REQ. A core model and a downstream
// model complete the 4-phase handshakes. The watchdog scenario is built only
// when AER_ARB_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_aer_out_rr_arbiter;
    import snn_ff_pkg::*;

    localparam int CORE_NUM  = 4;
    localparam int AER_WIDTH = 6;
    localparam int TIMEOUT   = 16;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [3:0]  core_req  = 4'b0;
    logic [23:0] core_addr = 24'b0;
    logic [3:0]  core_ack;
    logic        aer_req;
    logic [7:0]  aer_addr;
    logic        aer_ack   = 1'b0;
    logic        busy;
    logic        tmo_err;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  sb_item;
    int          repeat_left[4];
    bit          ack_enable = 1'b1;
    int          ack_delay  = 0;
    int          ack_wait   = 0;
    logic [1:0]  last_grant = 2'd0;
    logic        prev_req   = 1'b0;
    logic [3:0]  prev_ack   = 4'b0;

    aer_out_rr_arbiter #(
        .CORE_NUM  (CORE_NUM),
        .AER_WIDTH (AER_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .CORE_AEROUT_REQ  (core_req),
        .CORE_AEROUT_ADDR (core_addr),
        .CORE_AEROUT_ACK  (core_ack),
        .AEROUT_REQ       (aer_req),
        .AEROUT_ADDR      (aer_addr),
        .AEROUT_ACK       (aer_ack),
        .BUSY             (busy),
        .TIMEOUT_ERR      (tmo_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    task automatic bound_fail(input string name);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: wait bound expired, got timeout, want DUT event", name);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (aer_req !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) bound_fail(name);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!(busy === 1'b0 && core_req == 4'b0 && exp_q.size() == 0 && aer_ack == 1'b0 &&
                 (repeat_left[0] + repeat_left[1] + repeat_left[2] + repeat_left[3]) == 0)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) bound_fail(name);
    endtask

    // Scoreboard monitor: one expected grant per rising AEROUT_REQ, and the
    // core ack must go to the core of the most recent grant.
    initial begin
        forever begin
            @(negedge clk);
            if (aer_req === 1'b1 && prev_req === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_grant: got addr 0x%0h, want no grant", aer_addr);
                end else begin
                    sb_item    = exp_q.pop_front();
                    last_grant = sb_item[7:6];
                    check_output("grant_addr", aer_addr, sb_item);
                end
            end
            if (core_ack !== 4'b0 && prev_ack === 4'b0) begin
                check_output("core_ack_onehot", core_ack, 32'd1 << last_grant);
            end
            prev_req = aer_req;
            prev_ack = core_ack;
        end
    end

    // Core model: drop request on ack; optionally re-request once ack clears.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (core_req[i] && core_ack[i] === 1'b1) begin
                    core_req[i] = 1'b0;
                end else if (!core_req[i] && core_ack[i] === 1'b0 && repeat_left[i] > 0) begin
                    core_req[i] = 1'b1;
                    repeat_left[i]--;
                end
            end
        end
    end

    // Downstream model: ack after ack_delay cycles of request, release on drop.
    initial begin
        forever begin
            @(negedge clk);
            if (ack_enable) begin
                if (aer_req === 1'b1 && !aer_ack) begin
                    if (ack_wait >= ack_delay) begin
                        aer_ack  = 1'b1;
                        ack_wait = 0;
                    end else begin
                        ack_wait++;
                    end
                end else if (aer_req === 1'b0 && aer_ack) begin
                    aer_ack = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish, want finish");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int bad;
        int cnt;
        repeat_left = '{0, 0, 0, 0};

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_aerout_req", aer_req, 0);
        check_output("rst_core_ack", core_ack, 0);
        check_output("rst_aerout_addr", aer_addr, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_timeout_err", tmo_err, 0);
        check_output("rst_ptr", dut.ptr_q, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request from core 2: one-cycle latency, pointer ends at 3.
        core_addr[12 +: 6] = 6'h15;
        exp_q.push_back({2'd2, 6'h15});
        core_req[2] = 1'b1;
        @(negedge clk);
        check_output("single_latency_req", aer_req, 1);
        check_output("single_busy", busy, 1);
        wait_idle("single_idle", 50);
        check_output("single_ptr", dut.ptr_q, 3);
        check_output("single_ack_clear", core_ack, 0);

        // Wrap: pointer 3 with cores 1 and 3 requesting -> 3 then 1.
        core_addr[6 +: 6]  = 6'h0A;
        core_addr[18 +: 6] = 6'h33;
        exp_q.push_back({2'd3, 6'h33});
        exp_q.push_back({2'd1, 6'h0A});
        core_req[1] = 1'b1;
        core_req[3] = 1'b1;
        wait_idle("wrap_idle", 80);
        check_output("wrap_ptr", dut.ptr_q, 2);

        // Fairness from pointer 0: cores 0,1,3 each request twice.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        core_addr[0 +: 6]  = 6'h01;
        core_addr[6 +: 6]  = 6'h02;
        core_addr[18 +: 6] = 6'h03;
        for (int r = 0; r < 2; r++) begin
            exp_q.push_back({2'd0, 6'h01});
            exp_q.push_back({2'd1, 6'h02});
            exp_q.push_back({2'd3, 6'h03});
        end
        core_req = 4'b1011;
        repeat_left[0] = 1;
        repeat_left[1] = 1;
        repeat_left[3] = 1;
        wait_idle("fair_idle", 300);
        check_output("fair_ptr", dut.ptr_q, 0);

        // Backpressure: downstream ack held off for 50 cycles.
        ack_delay = 50;
        core_addr[6 +: 6] = 6'h2A;
        exp_q.push_back({2'd1, 6'h2A});
        core_req[1] = 1'b1;
        wait_req("bp_req");
        bad = 0;
        repeat (45) begin
            if (aer_req !== 1'b1 || aer_addr !== 8'h6A || core_ack !== 4'b0) bad++;
            @(negedge clk);
        end
        check_output("bp_stable", bad, 0);
        cnt = 0;
        while (core_ack === 4'b0 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 40) bound_fail("bp_core_ack");
        else check_output("bp_ack_low_before_core_ack", aer_ack, 0);
        wait_idle("bp_idle", 50);
        ack_delay = 0;

        // Reset while in DROP aborts the event; it is not retried.
        ack_enable = 1'b0;
        core_addr[0 +: 6] = 6'h11;
        exp_q.push_back({2'd0, 6'h11});
        core_req[0] = 1'b1;
        wait_req("mid_req");
        aer_ack = 1'b1;
        @(negedge clk);
        check_output("mid_drop_req_low", aer_req, 0);
        check_output("mid_in_drop", dut.state_q, ST_DROP);
        rst_n = 1'b0;
        @(negedge clk);
        check_output("mid_rst_req", aer_req, 0);
        check_output("mid_rst_core_ack", core_ack, 0);
        check_output("mid_rst_addr", aer_addr, 0);
        check_output("mid_rst_busy", busy, 0);
        check_output("mid_rst_state", dut.state_q, ST_IDLE);
        check_output("mid_rst_ptr", dut.ptr_q, 0);
        core_req[0] = 1'b0;
        aer_ack     = 1'b0;
        rst_n       = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (aer_req !== 1'b0 || busy !== 1'b0) bad++;
        end
        check_output("mid_no_retry", bad, 0);
        ack_enable = 1'b1;

`ifdef AER_ARB_TIMEOUT_EN
        // Watchdog: downstream never acks; 16 cycles in SEND then give up.
        ack_enable = 1'b0;
        core_addr[12 +: 6] = 6'h3F;
        exp_q.push_back({2'd2, 6'h3F});
        core_req[2] = 1'b1;
        wait_req("tmo_req");
        cnt = 0;
        while (aer_req === 1'b1 && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check_output("tmo_send_cycles", cnt, 16);
        check_output("tmo_err_set", tmo_err, 1);
        wait_idle("tmo_idle", 50);
        check_output("tmo_busy_clear", busy, 0);
        check_output("tmo_err_sticky", tmo_err, 1);
        ack_enable = 1'b1;
`else
        check_output("tmo_err_tied_low", tmo_err, 0);
`endif

        check_output("sb_leftover", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
